// File: rtl/logicnets_pkg.sv
// Shared constants and state encoding for the LogicNets MNIST front end.
// Pulled in by the input packer and its pixel binariser.
package logicnets_pkg;

  localparam int MNIST_PIXELS = 784;
  localparam int PIX_W        = 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/pixel_binariser.sv
// Grayscale-to-binary pixel compare: a pixel is set when it is at or above the threshold.
// Purely combinational; the packer registers the result in its fill buffer.
module pixel_binariser #(
  parameter int               PIX_W     = logicnets_pkg::PIX_W,
  parameter logic [PIX_W-1:0] THRESHOLD = 8'd128
) (
  input  logic [PIX_W-1:0] pix,
  output logic             bin
);

  assign bin = (pix >= THRESHOLD);

endmodule

// File: rtl/mnist_input_packer.sv
// Packs a raster stream of grayscale pixels into one binarised PIXELS-wide word
// that feeds the layer-0 LUT neurons directly.
module mnist_input_packer #(
  parameter int               PIXELS    = logicnets_pkg::MNIST_PIXELS,
  parameter int               PIX_W     = logicnets_pkg::PIX_W,
  parameter logic [PIX_W-1:0] THRESHOLD = 8'd128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIXELS-1:0] m_data,
  output logic              err_len
);

  import logicnets_pkg::*;

  localparam int CNT_W = $clog2(PIXELS + 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [PIXELS-1:0] fill;
  logic [PIXELS-1:0] next_img;
  logic              pix_bit;
  logic              accept;
  logic              last_pix;
  logic              out_free;

  pixel_binariser #(
    .PIX_W     (PIX_W),
    .THRESHOLD (THRESHOLD)
  ) u_bin (
    .pix (s_data),
    .bin (pix_bit)
  );

  assign s_ready  = (state == FILL) && !rst;
  assign accept   = s_valid && s_ready;
  assign last_pix = (cnt == CNT_W'(PIXELS - 1));
  assign out_free = !m_valid || m_ready;

  // Fill buffer with the current pixel merged in, so a completing pixel can go
  // straight to the output register without an extra cycle.
  always_comb begin
    next_img      = fill;
    next_img[cnt] = pix_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      fill    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (state == STALL) begin
        // Completed image waits here until the output slot drains.
        if (m_ready) begin
          m_data  <= fill;
          m_valid <= 1'b1;
          state   <= FILL;
          cnt     <= '0;
        end
      end else if (accept) begin
        if (last_pix) begin
          err_len <= !s_last;
          if (out_free) begin
            m_data  <= next_img;
            m_valid <= 1'b1;
            cnt     <= '0;
          end else begin
            fill  <= next_img;
            state <= STALL;
          end
        end else if (s_last) begin
          cnt     <= '0;
          err_len <= 1'b1;
        end else begin
          fill <= next_img;
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mnist_input_packer.sv
// Scoreboard bench for mnist_input_packer: a queue-based image model predicts every
// emitted image and every length error; a monitor compares what the DUT presents.
module tb_mnist_input_packer;

  localparam int PIXELS = 784;
  localparam int BUDGET = 5000;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [PIXELS-1:0] m_data;
  logic              err_len;

  int checks = 0;
  int fails  = 0;

  logic [PIXELS-1:0] exp_q[$];
  bit                cur[$];
  int                exp_err      = 0;
  int                err_seen     = 0;
  int                stall_cycles = 0;
  int                ready_mode   = 1;

  always #5 clk = ~clk;

  mnist_input_packer #(
    .PIXELS    (PIXELS),
    .PIX_W     (8),
    .THRESHOLD (8'd128)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
  );

  // Downstream ready: 0 = held low, 1 = held high, 2 = random.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected images on handshakes, checks hold stability, counts error pulses.
  initial begin
    logic              hold;
    logic [PIXELS-1:0] hold_data;
    logic [PIXELS-1:0] exp_img;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (err_len) err_seen++;
        if (hold) begin
          checks++;
          if (!m_valid || m_data !== hold_data) begin
            fails++;
            $display("FAIL hold_stable: m_valid=%0b data_changed=%0b, required m_valid=1 data_changed=0",
                     m_valid, (m_data !== hold_data));
          end
        end
        if (m_valid && m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_image: got an image, required none pending");
          end else begin
            exp_img = exp_q.pop_front();
            if (m_data !== exp_img) begin
              fails++;
              $display("FAIL image_data: got %h required %h", m_data, exp_img);
            end
          end
        end
        hold      = m_valid && !m_ready;
        hold_data = m_data;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference behaviour: pixels accumulate in order; a full image is emitted,
  // a short one is dropped; any length disagreement with s_last is an error.
  task automatic model_accept(input logic [7:0] v, input bit last);
    logic [PIXELS-1:0] img;
    cur.push_back(v >= 8'd128);
    if (cur.size() == PIXELS) begin
      for (int k = 0; k < PIXELS; k++) img[k] = cur[k];
      exp_q.push_back(img);
      if (!last) exp_err++;
      cur.delete();
    end else if (last) begin
      exp_err++;
      cur.delete();
    end
  endtask

  task automatic send_pixel(input logic [7:0] v, input bit last);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    @(negedge clk);
    while (!s_ready) begin
      w++;
      if (w > BUDGET) begin
        fails++;
        $display("FAIL s_ready_timeout: waited %0d cycles, required at most %0d", w, BUDGET);
        $fatal(1, "s_ready never returned");
      end
      @(negedge clk);
    end
    stall_cycles += w;
    @(posedge clk);
    model_accept(v, last);
    #1;
  endtask

  // mode 0: all 200, mode 1: 127/128 alternating, mode 2: random.
  task automatic send_image(input int n, input int mode, input int last_at, input int gap_pct);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      case (mode)
        0:       v = 8'd200;
        1:       v = (i % 2 == 1) ? 8'd128 : 8'd127;
        default: v = 8'($urandom_range(0, 255));
      endcase
      send_pixel(v, (i == last_at));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int n;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s_ready_low", int'(s_ready), 0);
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_err_len", int'(err_len), 0);
    chk("reset_m_data_zero", int'(m_data == '0), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;

    // All-200 image, back to back, downstream always ready.
    stall_cycles = 0;
    send_image(PIXELS, 0, PIXELS - 1, 0);
    @(negedge clk);
    chk("latency_m_valid", int'(m_valid), 1);
    chk("all_ones_m_data", int'(m_data == {PIXELS{1'b1}}), 1);
    chk("throughput_no_stall", stall_cycles, 0);
    settle(4);
    chk("err_after_full", err_seen, 0);

    // Threshold edge: 127 below, 128 at threshold.
    send_image(PIXELS, 1, PIXELS - 1, 0);
    settle(4);
    chk("alt_err", err_seen, exp_err);
    chk("alt_drained", exp_q.size(), 0);

    // Two images while downstream is stalled for 900 cycles.
    ready_mode = 0;
    settle(2);
    send_image(PIXELS, 2, PIXELS - 1, 0);
    send_image(PIXELS, 2, PIXELS - 1, 0);
    @(negedge clk);
    chk("stall_s_ready_low", int'(s_ready), 0);
    repeat (900) @(negedge clk);
    chk("stall_s_ready_still_low", int'(s_ready), 0);
    chk("stall_m_valid", int'(m_valid), 1);
    chk("stall_pending_images", exp_q.size(), 2);
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("no_bubble_m_valid", int'(m_valid), 1);
    chk("stall_s_ready_back", int'(s_ready), 1);
    @(negedge clk);
    chk("stall_drained", exp_q.size(), 0);
    settle(2);

    // Short image: s_last at pixel 99, then a full image.
    e0 = err_seen;
    send_image(100, 2, 99, 0);
    settle(3);
    chk("short_err_once", err_seen - e0, 1);
    chk("short_no_image", int'(m_valid), 0);
    send_image(PIXELS, 2, PIXELS - 1, 0);
    settle(4);
    chk("short_then_full_err", err_seen - e0, 1);
    chk("short_then_full_drained", exp_q.size(), 0);

    // Full image with no s_last.
    e0 = err_seen;
    send_image(PIXELS, 2, -1, 0);
    settle(4);
    chk("missing_last_err_once", err_seen - e0, 1);
    chk("missing_last_drained", exp_q.size(), 0);

    // Reset after 401 pixels of an image.
    e0 = err_seen;
    send_image(401, 2, -1, 0);
    rst = 1'b1;
    cur.delete();
    @(negedge clk);
    chk("midreset_s_ready_low", int'(s_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_m_valid", int'(m_valid), 0);
    chk("midreset_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;
    send_image(PIXELS, 2, PIXELS - 1, 0);
    settle(4);
    chk("midreset_no_err", err_seen - e0, 0);
    chk("midreset_drained", exp_q.size(), 0);

    // Random traffic: random pixels, input gaps, random downstream ready, occasional short images.
    ready_mode = 2;
    for (int img = 0; img < 6; img++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PIXELS - 1)) : PIXELS;
      send_image(n, 2, n - 1, 20);
    end
    ready_mode = 1;
    settle(20);
    chk("random_drained", exp_q.size(), 0);
    chk("random_err_count", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mnist_input_packer.md
MNIST_INPUT_PACKER -- requirements
Module: mnist_input_packer

Interface
REQ-001 SHALL have parameter PIXELS, default 784, meaning pixels per image and the width of m_data.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the width of a grayscale pixel.
REQ-003 SHALL have parameter THRESHOLD, default 8'd128, meaning the binarisation threshold, unsigned.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port s_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port s_ready  output  1  packer accepts a pixel this cycle.
REQ-008 SHALL have port s_data  input  PIX_W  grayscale pixel, raster order.
REQ-009 SHALL have port s_last  input  1  marks the final pixel of an image.
REQ-010 SHALL have port m_valid  output  1  packed image valid towards layer-0 LUT neurons.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the image.
REQ-012 SHALL have port m_data  output  PIXELS  packed binarised image.
REQ-013 SHALL have port err_len  output  1  one-cycle pulse on an image-length error.

Function
REQ-014 SHALL transfer a pixel only on a cycle where s_valid=1 and s_ready=1; an image leaves only on a cycle where m_valid=1 and m_ready=1.
REQ-015 SHALL binarise each accepted pixel to bit = (s_data >= THRESHOLD) and write it to fill-buffer bit index cnt; pixel k of an image maps to m_data[k].
REQ-016 SHALL keep cnt, width clog2(PIXELS+1), incrementing it on each accepted pixel.
REQ-017 SHALL define two states, FILL (s_ready=1) and STALL (s_ready=0), where STALL means the fill buffer is complete while the output register is occupied.
REQ-018 SHALL treat the fill buffer as complete when the accepted pixel has cnt=PIXELS-1.
- If the output register is free, or is emptied on the same cycle, the buffer copies into the output register on the next edge, m_valid=1 and cnt=0.
- Otherwise the state becomes STALL.
REQ-019 SHALL, in STALL, copy the fill buffer into the output register and return to FILL with cnt=0 on the first cycle m_ready=1; there SHALL be no bubble between images.
REQ-020 SHALL, on an accepted pixel with s_last=1 and cnt<PIXELS-1, discard the partial image, set cnt=0 and pulse err_len.
REQ-021 SHALL, on a completing pixel with s_last=0, still emit the image and pulse err_len.
REQ-022 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-023 SHALL have a latency of one cycle from acceptance of the final pixel to m_valid=1 when the output register is free.
REQ-024 SHALL sustain 1 pixel per cycle when m_ready=1 continuously.
REQ-025 SHALL make all outputs registered except s_ready, which is a decode of the state.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set state=FILL, cnt=0, m_valid=0, m_data=0, err_len=0 and clear the fill buffer.
REQ-027 SHALL, when rst is asserted mid-image or mid-stall, drop all buffered data with no err_len pulse.
REQ-028 SHALL drive s_ready=0 during the cycle rst=1 and s_ready=1 on the first cycle after it.

Structure
REQ-029 SHALL place the state enum (FILL, STALL) and the constants MNIST_PIXELS=784 and PIX_W=8 in shared package logicnets_pkg.
REQ-030 SHALL have one natural sub-module, pixel_binariser (combinational compare); everything else stays flat.
REQ-031 SHALL ensure m_data connects bit-for-bit to the layer-0 neuron input slices with no further registering.

Verification
REQ-032 SHALL cover: 784 pixels with value 200 back-to-back, s_last on pixel 783, m_ready=1 -> m_valid one cycle later, m_data all ones, err_len=0.
REQ-033 SHALL cover: pixel values 127 and 128 alternating -> m_data[k]=k[0] (even pixels 0, odd pixels 1).
REQ-034 SHALL cover: two images streamed back-to-back with m_ready=0 for 900 cycles after the first completes -> s_ready drops after pixel 783 of image 2, m_data holds image 1; on m_ready=1 image 2 appears next cycle and s_ready returns.
REQ-035 SHALL cover: s_last at pixel 99 -> err_len pulses once, no m_valid, and the next 784 pixels form a correct image.
REQ-036 SHALL cover: 784 pixels without s_last -> image emitted and err_len pulses once.
REQ-037 SHALL cover: rst=1 after pixel 400 -> m_valid=0, cnt=0, and a following full image is emitted correctly with no err_len.
